// File: rtl/ras_spec_ctrl_if.sv
// Fetch/branch-resolution <-> RAS speculation controller bundle (master = pipeline, slave = controller).
// undo_cnt is present only when RAS_SPEC_STATS_EN is defined.
interface ras_spec_ctrl_if #(
    parameter int LOG_AW = 3
);
    localparam int TAG_W = LOG_AW + 1;

    logic             if_valid;
    logic             if_push;
    logic             if_pop;
    logic [TAG_W-1:0] if_tag;
    logic             commit_valid;
    logic             flush_valid;
    logic [TAG_W-1:0] flush_tag;
    logic             flush_none;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_undo_push;
    logic             ras_undo_pop;
    logic             busy;
    logic             full;
    logic             ovf_err;
`ifdef RAS_SPEC_STATS_EN
    logic [15:0]      undo_cnt;

    modport master (
        output if_valid, if_push, if_pop, commit_valid, flush_valid, flush_tag, flush_none,
        input  if_tag, ras_push, ras_pop, ras_undo_push, ras_undo_pop, busy, full, ovf_err,
        input  undo_cnt
    );

    modport slave (
        input  if_valid, if_push, if_pop, commit_valid, flush_valid, flush_tag, flush_none,
        output if_tag, ras_push, ras_pop, ras_undo_push, ras_undo_pop, busy, full, ovf_err,
        output undo_cnt
    );
`else
    modport master (
        output if_valid, if_push, if_pop, commit_valid, flush_valid, flush_tag, flush_none,
        input  if_tag, ras_push, ras_pop, ras_undo_push, ras_undo_pop, busy, full, ovf_err
    );

    modport slave (
        input  if_valid, if_push, if_pop, commit_valid, flush_valid, flush_tag, flush_none,
        output if_tag, ras_push, ras_pop, ras_undo_push, ras_undo_pop, busy, full, ovf_err
    );
`endif
endinterface

// File: rtl/ras_spec_ctrl.sv
// RAS speculation controller: tags and logs speculative RAS ops, retires them on commit and
// replays pointer undo newest-first after a redirect. RAS_SPEC_STATS_EN adds the undo_cnt counter.
module ras_spec_ctrl #(
    parameter int LOG_AW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    ras_spec_ctrl_if.slave bus
);
    localparam int TAG_W = LOG_AW + 1;
    localparam int DEPTH = 1 << LOG_AW;
    localparam logic [0:0]       ST_IDLE = 1'b0;
    localparam logic [0:0]       ST_UNDO = 1'b1;
    localparam logic [TAG_W-1:0] ONE     = TAG_W'(1);
    localparam logic [TAG_W-1:0] WRAP    = {1'b1, {LOG_AW{1'b0}}};
    localparam logic [1:0]       OP_PUSH = 2'b10;
    localparam logic [1:0]       OP_POP  = 2'b01;

    logic [0:0]        state, state_next;
    logic [TAG_W-1:0]  head, tail, target;
    logic [TAG_W-1:0]  tail_next, target_next;
    logic [1:0]        op_log [DEPTH];
    logic              undo_push_q, undo_pop_q, ovf_q;

    logic              full, empty, op_req, issue, commit;
    logic [TAG_W-1:0]  head_ac, tail_dec, raw_tgt, idle_tgt, undo_tgt;
    logic [TAG_W-1:0]  dist_raw, dist_tail, dist_cur;
    logic [LOG_AW-1:0] peek_idx;
    logic [1:0]        peek_op;

    assign full     = (head ^ tail) == WRAP;
    assign empty    = head == tail;
    assign op_req   = bus.if_valid & (bus.if_push | bus.if_pop);
    assign issue    = (state == ST_IDLE) & op_req & ~full & ~bus.flush_valid;
    assign commit   = bus.commit_valid & ~empty;
    assign head_ac  = head + TAG_W'(commit);
    assign tail_dec = tail - ONE;

    // Targets are ranked by age as their distance from the post-commit head.
    assign raw_tgt   = bus.flush_none ? head_ac : bus.flush_tag + ONE;
    assign dist_raw  = raw_tgt - head_ac;
    assign dist_tail = tail - head_ac;
    assign dist_cur  = target - head_ac;
    assign idle_tgt  = (dist_raw > dist_tail) ? head_ac : raw_tgt;
    assign undo_tgt  = (bus.flush_valid && (dist_raw < dist_cur)) ? raw_tgt : target;

    always_comb begin
        state_next  = state;
        tail_next   = tail;
        target_next = target;
        if (state == ST_IDLE) begin
            if (issue)
                tail_next = tail + ONE;
            if (bus.flush_valid && (idle_tgt != tail)) begin
                state_next  = ST_UNDO;
                target_next = idle_tgt;
            end
        end else begin
            tail_next   = tail_dec;
            target_next = undo_tgt;
            if ((tail_dec == undo_tgt) || (tail_dec == head_ac))
                state_next = ST_IDLE;
        end
    end

    // Next cycle's undo strobe is decoded now from the entry that will sit at tail-1.
    assign peek_idx = LOG_AW'(tail_next - ONE);
    assign peek_op  = op_log[peek_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            head        <= '0;
            tail        <= '0;
            target      <= '0;
            undo_push_q <= 1'b0;
            undo_pop_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state       <= state_next;
            head        <= head_ac;
            tail        <= tail_next;
            target      <= target_next;
            undo_push_q <= (state_next == ST_UNDO) && (peek_op == OP_POP);
            undo_pop_q  <= (state_next == ST_UNDO) && (peek_op == OP_PUSH);
            if (op_req && (full || (state == ST_UNDO)))
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            op_log[tail[LOG_AW-1:0]] <= {bus.if_push, bus.if_pop};
    end

    assign bus.if_tag        = tail;
    assign bus.ras_push      = issue & bus.if_push;
    assign bus.ras_pop       = issue & bus.if_pop;
    assign bus.ras_undo_push = undo_push_q;
    assign bus.ras_undo_pop  = undo_pop_q;
    assign bus.busy          = (state == ST_UNDO);
    assign bus.full          = full;
    assign bus.ovf_err       = ovf_q;

`ifdef RAS_SPEC_STATS_EN
    logic [15:0] undo_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            undo_cnt_q <= '0;
        else if ((undo_push_q | undo_pop_q) && (undo_cnt_q != 16'hFFFF))
            undo_cnt_q <= undo_cnt_q + 16'd1;
    end

    assign bus.undo_cnt = undo_cnt_q;
`endif
endmodule
